float_to_int: RTL and testbench
===============================

FLOAT_TO_INT -- requirements
Module: float_to_int

Interface
REQ-001 The block SHALL have one clock and an asynchronous, active-high reset.
REQ-002 The ports SHALL be, clock and reset first:
- clk  in  1  system clock, rising edge
- rst  in  1  asynchronous active-high reset
- input_a  in  32  IEEE-754 single-precision operand
- input_a_stb  in  1  producer has valid input_a
- input_a_ack  out  1  block ready to accept input_a
- output_z  out  32  signed two's-complement integer result
- output_z_stb  out  1  output_z valid
- output_z_ack  in  1  consumer accepts output_z

Function
REQ-003 The block SHALL convert input_a to a signed 32-bit integer, truncating toward zero.
REQ-004 The FSM SHALL have the states get_a, unpack, special, align, pack and put_z, encoded in 3 bits.
REQ-005 get_a: the block SHALL register input_a_ack=1; on the first edge where input_a_ack=1 and input_a_stb=1 it SHALL capture input_a, register input_a_ack=0 and go to unpack.
REQ-006 unpack: the block SHALL register the fields for the next state:
- sign s = a[31]
- exponent e = a[30:23] - 127 (signed, at least 9 bits)
- mantissa m = {1'b1, a[22:0], 8'b0} (32 bits)
Then it SHALL go to special.
REQ-007 special, with the cases checked in this priority order:
- e >= 31 (overflow, +/-inf, NaN, -2^31): result 0x80000000, go to pack.
- e < 0 (zero, denormal, |x| < 1): result 0, go to pack.
- otherwise: go to align.
REQ-008 align: each cycle, if e == 31 the block SHALL go to pack; otherwise it SHALL shift m right by 1 (zero fill) and increment e.
REQ-009 Align SHALL therefore take (32 - e_initial) cycles, with no early exit.
REQ-010 pack: for the normal path, z SHALL be -m when s=1, else m.
REQ-011 pack: for the special path, z SHALL hold the value chosen in special, with no negation.
REQ-012 pack SHALL then go to put_z.
REQ-013 put_z: the block SHALL register output_z_stb=1 and output_z=z.
REQ-014 put_z: on the first edge where output_z_stb=1 and output_z_ack=1, the block SHALL clear output_z_stb and return to get_a.
REQ-015 output_z SHALL stay stable while output_z_stb=1.
REQ-016 The block SHALL accept no new input until the current result has been acknowledged; input_a_ack SHALL be 0 in every state except get_a.
REQ-017 Latency from the capture edge to output_z_stb=1 SHALL be 4 cycles on the special path and (36 - e_initial) cycles on the normal path.
REQ-018 output_z_ack asserted outside put_z SHALL be ignored; input_a_stb asserted outside get_a SHALL be ignored.
REQ-019 Negative zero (0x80000000 input) SHALL produce 0.
REQ-020 Both +2^31 and -2^31 SHALL produce 0x80000000.

Reset
REQ-021 While rst=1, the block SHALL hold, independent of clk:
- state = get_a
- input_a_ack = 0
- output_z_stb = 0
- output_z = 0
REQ-022 Reset asserted mid-conversion or in put_z SHALL abandon the operation with no output strobe.
REQ-023 After rst deasserts, input_a_ack SHALL rise on the first rising clk edge.
REQ-024 Internal datapath registers need not be reset.

Verification
REQ-025 A bench SHALL cover: 0x3F800000 (1.0) -> 0x00000001, output_z_stb high exactly 36 cycles after the capture edge.
REQ-026 A bench SHALL cover: 0xC0200000 (-2.5) -> 0xFFFFFFFE; 0x3F400000 (0.75) -> 0x00000000, in 4 cycles.
REQ-027 A bench SHALL cover: 0x4F000000 (2^31), 0xCF000000 (-2^31), 0x7F800000 (+inf) and 0x7FC00000 (NaN) -> 0x80000000 each; 0x4EFFFFFF -> 0x7FFFFF80.
REQ-028 A bench SHALL cover: 0x80000000 (-0.0) and 0x00000001 (denormal) -> 0x00000000.
REQ-029 A bench SHALL cover: output_z_ack held low for 10 cycles in put_z -> output_z and output_z_stb stable; input_a_stb pulses ignored; completion on the first ack.
REQ-030 A bench SHALL cover: rst pulsed during align -> outputs reset immediately, no strobe; the next operand (0x42F60000, 123.0) -> 0x0000007B.

Source files
------------

// File: rtl/float_to_int_if.sv
// float_to_int_if
// Handshake bundle between a float producer, the float_to_int converter and
// the integer consumer. Each direction uses a strobe/ack pair; a transfer
// happens on the rising clock edge where both are high.
//
// Signals:
//   input_a       32  IEEE-754 single-precision operand (producer -> block)
//   input_a_stb    1  producer has valid input_a
//   input_a_ack    1  block ready to accept input_a
//   output_z      32  signed two's-complement result (block -> consumer)
//   output_z_stb   1  output_z valid
//   output_z_ack   1  consumer accepts output_z
//
// Modports:
//   master  the environment side (drives operands, acknowledges results)
//   slave   the converter side
interface float_to_int_if;
  logic [31:0] input_a;
  logic        input_a_stb;
  logic        input_a_ack;
  logic [31:0] output_z;
  logic        output_z_stb;
  logic        output_z_ack;

  modport master (
    output input_a,
    output input_a_stb,
    input  input_a_ack,
    input  output_z,
    input  output_z_stb,
    output output_z_ack
  );

  modport slave (
    input  input_a,
    input  input_a_stb,
    output input_a_ack,
    output output_z,
    output output_z_stb,
    input  output_z_ack
  );
endinterface

// File: rtl/float_to_int.sv
// float_to_int
// Converts an IEEE-754 single-precision value to a signed 32-bit integer,
// truncating toward zero. One operand is processed at a time: a new operand
// is only accepted after the previous result has been acknowledged.
//
// Out-of-range magnitudes (|x| >= 2^31), infinities and NaNs all map to
// 0x80000000. Zeros, denormals and |x| < 1 map to 0.
//
// The alignment step shifts the mantissa one bit per cycle until the
// exponent reaches 31, so normal-path latency depends on the operand
// exponent: (36 - e) cycles from capture to output strobe; special values
// take 4 cycles.
//
// Ports:
//   clk   system clock, rising edge
//   rst   asynchronous active-high reset
//   bus   float_to_int_if.slave handshake bundle (input_a / output_z)
module float_to_int (
  input  logic            clk,
  input  logic            rst,
  float_to_int_if.slave   bus
);

  typedef enum logic [2:0] {
    GET_A   = 3'd0,
    UNPACK  = 3'd1,
    SPECIAL = 3'd2,
    ALIGN   = 3'd3,
    PACK    = 3'd4,
    PUT_Z   = 3'd5
  } state_t;

  state_t state;
  state_t state_next;

  // Datapath registers (not reset; they are always rewritten before use)
  logic [31:0]        a_reg;
  logic [31:0]        a_next;
  logic               s_reg;
  logic               s_next;
  logic signed [9:0]  e_reg;
  logic signed [9:0]  e_next;
  logic [31:0]        m_reg;
  logic [31:0]        m_next;
  logic [31:0]        z_reg;
  logic [31:0]        z_next;
  logic               special_reg;
  logic               special_next;

  // Next values of the registered handshake outputs
  logic               ack_next;
  logic               stb_next;
  logic [31:0]        out_next;

  logic               capture;
  logic               release_z;

  // A transfer in either direction needs both sides of the handshake high.
  assign capture   = bus.input_a_ack & bus.input_a_stb;
  assign release_z = bus.output_z_stb & bus.output_z_ack;

  // State register; reset returns to GET_A regardless of the clock so an
  // operation in flight is simply dropped.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= GET_A;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic. ALIGN has no early exit: it walks the exponent all
  // the way up to 31 even when the remaining mantissa is already zero.
  always_comb begin
    state_next = state;
    case (state)
      GET_A:   if (capture) state_next = UNPACK;
      UNPACK:  state_next = SPECIAL;
      SPECIAL: begin
        if (e_reg >= 10'sd31) begin
          state_next = PACK;
        end else if (e_reg < 10'sd0) begin
          state_next = PACK;
        end else begin
          state_next = ALIGN;
        end
      end
      ALIGN:   if (e_reg == 10'sd31) state_next = PACK;
      PACK:    state_next = PUT_Z;
      PUT_Z:   if (release_z) state_next = GET_A;
      default: state_next = GET_A;
    endcase
  end

  // Output and datapath next-value logic.
  // The mantissa is held with its hidden one at bit 31, so shifting right
  // (31 - e) times leaves the integer part in the low bits. The special
  // flag tells PACK whether z was already decided in SPECIAL, in which
  // case it must be passed through without sign handling.
  always_comb begin
    a_next       = a_reg;
    s_next       = s_reg;
    e_next       = e_reg;
    m_next       = m_reg;
    z_next       = z_reg;
    special_next = special_reg;
    ack_next     = 1'b0;
    stb_next     = 1'b0;
    out_next     = bus.output_z;

    case (state)
      GET_A: begin
        ack_next = ~capture;
        if (capture) begin
          a_next = bus.input_a;
        end
      end

      UNPACK: begin
        s_next       = a_reg[31];
        e_next       = $signed({2'b00, a_reg[30:23]}) - 10'sd127;
        m_next       = {1'b1, a_reg[22:0], 8'h00};
        special_next = 1'b0;
      end

      SPECIAL: begin
        if (e_reg >= 10'sd31) begin
          z_next       = 32'h8000_0000;
          special_next = 1'b1;
        end else if (e_reg < 10'sd0) begin
          z_next       = 32'h0000_0000;
          special_next = 1'b1;
        end
      end

      ALIGN: begin
        if (e_reg != 10'sd31) begin
          m_next = m_reg >> 1;
          e_next = e_reg + 10'sd1;
        end
      end

      PACK: begin
        if (!special_reg) begin
          z_next = s_reg ? (~m_reg + 32'd1) : m_reg;
        end
      end

      PUT_Z: begin
        // The strobe rises on the first cycle here and drops on the
        // accepting edge; z does not change while in PUT_Z, so output_z
        // stays stable for as long as the strobe is high.
        stb_next = ~release_z;
        out_next = z_reg;
      end

      default: ;
    endcase
  end

  // Registered handshake outputs; these are the values visible during reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bus.input_a_ack  <= 1'b0;
      bus.output_z_stb <= 1'b0;
      bus.output_z     <= 32'h0000_0000;
    end else begin
      bus.input_a_ack  <= ack_next;
      bus.output_z_stb <= stb_next;
      bus.output_z     <= out_next;
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    a_reg       <= a_next;
    s_reg       <= s_next;
    e_reg       <= e_next;
    m_reg       <= m_next;
    z_reg       <= z_next;
    special_reg <= special_next;
  end

endmodule

// File: tb/tb_float_to_int.sv
// tb_float_to_int
// Directed bench for float_to_int: drives single operands through the
// strobe/ack handshake and compares results and latency against
// hand-computed values. Also exercises back-pressure on the output and an
// asynchronous reset in the middle of a conversion.
module tb_float_to_int;

  logic clk = 1'b0;
  logic rst = 1'b0;
  int   checks = 0;
  int   errors = 0;

  float_to_int_if bus();

  float_to_int dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  // Single comparison point; every check in the bench goes through here.
  task automatic check_output(input string tag, input logic [31:0] observed,
                              input logic [31:0] expected);
    checks++;
    assert (observed === expected)
    else begin
      errors++;
      $error("[TB] FAIL %s observed=%h expected=%h", tag, observed, expected);
    end
  endtask

  // Present an operand and wait (bounded) for it to be captured.
  task automatic apply_stimulus(input logic [31:0] a, input string tag);
    int n;
    n = 0;
    @(negedge clk);
    bus.input_a     = a;
    bus.input_a_stb = 1'b1;
    while (!bus.input_a_ack && n < 20) begin
      @(negedge clk);
      n++;
    end
    check_output({tag, "_ready"}, {31'b0, bus.input_a_ack}, 32'd1);
    @(posedge clk);
    #1;
    bus.input_a_stb = 1'b0;
    check_output({tag, "_ack_drop"}, {31'b0, bus.input_a_ack}, 32'd0);
  endtask

  // Count rising edges from capture until output_z_stb is seen (bounded).
  task automatic wait_result(output int cycles);
    cycles = 0;
    do begin
      @(posedge clk);
      #1;
      cycles++;
    end while (!bus.output_z_stb && cycles < 200);
  endtask

  // Accept the pending result and confirm the strobe clears on that edge.
  task automatic release_result(input string tag);
    @(negedge clk);
    bus.output_z_ack = 1'b1;
    @(posedge clk);
    #1;
    bus.output_z_ack = 1'b0;
    check_output({tag, "_stb_clear"}, {31'b0, bus.output_z_stb}, 32'd0);
  endtask

  task automatic run_vector(input logic [31:0] a, input logic [31:0] exp_z,
                            input int exp_lat, input string tag);
    int lat;
    apply_stimulus(a, tag);
    wait_result(lat);
    check_output({tag, "_latency"}, 32'(lat), 32'(exp_lat));
    check_output({tag, "_z"}, bus.output_z, exp_z);
    release_result(tag);
  endtask

  initial begin
    int lat;
    int strobes;

    bus.input_a      = 32'h0;
    bus.input_a_stb  = 1'b0;
    bus.output_z_ack = 1'b0;

    // Reset values must appear without any clock edge.
    #2 rst = 1'b1;
    #1;
    check_output("reset_ack", {31'b0, bus.input_a_ack}, 32'd0);
    check_output("reset_stb", {31'b0, bus.output_z_stb}, 32'd0);
    check_output("reset_z", bus.output_z, 32'h0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("ack_after_reset", {31'b0, bus.input_a_ack}, 32'd1);

    // Normal path: latency 36 - e
    run_vector(32'h3F80_0000, 32'h0000_0001, 36, "one");
    run_vector(32'hC020_0000, 32'hFFFF_FFFE, 35, "minus_2p5");
    run_vector(32'h4EFF_FFFF, 32'h7FFF_FF80, 6,  "max_below_2p31");

    // Special path: latency 4
    run_vector(32'h3F40_0000, 32'h0000_0000, 4, "0p75");
    run_vector(32'h4F00_0000, 32'h8000_0000, 4, "2p31");
    run_vector(32'hCF00_0000, 32'h8000_0000, 4, "minus_2p31");
    run_vector(32'h7F80_0000, 32'h8000_0000, 4, "inf");
    run_vector(32'h7FC0_0000, 32'h8000_0000, 4, "nan");
    run_vector(32'h8000_0000, 32'h0000_0000, 4, "neg_zero");
    run_vector(32'h0000_0001, 32'h0000_0000, 4, "denormal");

    // Output back-pressure: result held, new operands ignored.
    apply_stimulus(32'hC020_0000, "hold");
    wait_result(lat);
    check_output("hold_latency", 32'(lat), 32'd35);
    check_output("hold_z", bus.output_z, 32'hFFFF_FFFE);
    for (int i = 0; i < 10; i++) begin
      @(negedge clk);
      bus.input_a     = 32'h3F80_0000 + 32'(i);
      bus.input_a_stb = i[0];
      @(posedge clk);
      #1;
      check_output("hold_stb", {31'b0, bus.output_z_stb}, 32'd1);
      check_output("hold_z_stable", bus.output_z, 32'hFFFF_FFFE);
      check_output("hold_no_ack", {31'b0, bus.input_a_ack}, 32'd0);
    end
    bus.input_a_stb = 1'b0;
    release_result("hold");
    run_vector(32'h4040_0000, 32'h0000_0003, 35, "three");

    // Reset in the middle of ALIGN drops the conversion.
    apply_stimulus(32'h3F80_0000, "abort");
    repeat (10) @(posedge clk);
    @(negedge clk);
    #2 rst = 1'b1;
    #1;
    check_output("abort_ack", {31'b0, bus.input_a_ack}, 32'd0);
    check_output("abort_stb", {31'b0, bus.output_z_stb}, 32'd0);
    check_output("abort_z", bus.output_z, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    @(posedge clk);
    #1;
    check_output("abort_ack_rise", {31'b0, bus.input_a_ack}, 32'd1);
    strobes = 0;
    for (int i = 0; i < 40; i++) begin
      @(posedge clk);
      #1;
      if (bus.output_z_stb) strobes++;
    end
    check_output("abort_no_strobe", 32'(strobes), 32'd0);
    run_vector(32'h42F6_0000, 32'h0000_007B, 30, "123");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

  // Global time limit so the bench always terminates.
  initial begin
    #1000000;
    $display("[TB] FAIL watchdog observed=timeout expected=completion");
    $fatal(1, "[TB] time limit reached");
  end

endmodule
